// File: rtl/router_pkg.sv
// Shared router definitions: flit types, port count and the output arbiter state encoding.
package router_pkg;

    localparam int N_PORT = 4;

    localparam logic [1:0] PKT_HEAD = 2'b10;
    localparam logic [1:0] PKT_BODY = 2'b00;
    localparam logic [1:0] PKT_TAIL = 2'b11;
    localparam logic [1:0] PKT_SGL  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_XFER = 2'b10
    } osbm_st_e;

    function automatic logic [N_PORT-1:0] onehot(input logic [1:0] idx);
        logic [N_PORT-1:0] one;
        one = {{(N_PORT-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin chooser: first requester at or after ptr, wrapping mod N_PORT.
module rr_pick
    import router_pkg::*;
(
    input  logic [N_PORT-1:0] req,
    input  logic [1:0]        ptr,
    output logic [1:0]        gnt_idx,
    output logic              any
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        any     = |req;
        for (int k = N_PORT - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx])
                gnt_idx = idx;
        end
    end

endmodule

// File: rtl/osbm.sv
// Output-side switch arbiter: round-robin grant of one output port, flit write-through,
// release on tail/single flit or on an idle watchdog.
module osbm
    import router_pkg::*;
#(
    parameter int TMO_W = 8,
    parameter int TMO   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PORT-1:0] req,
    output logic [N_PORT-1:0] ack,
    output logic [1:0]        sel,
    output logic              busy,
    input  logic              fvld,
    input  logic [1:0]        pkti,
    output logic              we,
    output logic              err
);

    osbm_st_e         state;
    logic [1:0]       ptr;
    logic [TMO_W-1:0] cnt;

    logic [1:0] gidx;
    logic       gany;
    logic       last;
    logic       tmo_hit;

    rr_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (gidx),
        .any     (gany)
    );

    assign last    = fvld && (pkti == PKT_TAIL || pkti == PKT_SGL);
    assign tmo_hit = !fvld && (cnt == TMO_W'(TMO - 1));

    // Gated by state so a mid-transfer reset drops the FIFO write immediately.
    assign we = (state == ST_XFER) && fvld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            ack   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack  <= '0;
                    busy <= 1'b0;
                    if (gany) begin
                        sel   <= gidx;
                        ack   <= onehot(gidx);
                        busy  <= 1'b1;
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack   <= '0;
                    cnt   <= '0;
                    state <= ST_XFER;
                end
                ST_XFER: begin
                    ack <= '0;
                    if (fvld) begin
                        cnt <= '0;
                        if (last) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            ptr   <= sel + 2'd1;
                        end
                    end else if (tmo_hit) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= sel + 2'd1;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osbm.sv
// Randomized self-checking bench for osbm against a packet-level round-robin model.
module tb_osbm;
    import router_pkg::*;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       busy;
    logic       fvld;
    logic [1:0] pkti;
    logic       we;
    logic       err;

    int nchk  = 0;
    int nfail = 0;
    int mptr  = 0;
    bit merr  = 1'b0;

    osbm #(.TMO_W(8), .TMO(TMO)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .ack  (ack),
        .sel  (sel),
        .busy (busy),
        .fvld (fvld),
        .pkti (pkti),
        .we   (we),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req  = 4'b0000;
        fvld = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_we", we, 0);
            chk("idle_err", err, merr);
            step();
        end
    endtask

    // Entered with req already driven and the DUT in IDLE this cycle; returns in the
    // bubble cycle after release with req=nreq visible.
    task automatic pkt(input logic [3:0] r, input int nfl, input int gapmax,
                       input bit tmo, input logic [3:0] nreq);
        int g;
        int gap;
        g = rr(r, mptr);
        @(negedge clk);
        chk("pre_busy", busy, 0);
        chk("pre_ack", ack, 0);
        chk("pre_err", err, merr);
        step();
        req = 4'($urandom);
        @(negedge clk);
        chk("ack", ack, 32'(4'b0001 << g));
        chk("sel", sel, g);
        chk("ack_busy", busy, 1);
        chk("ack_we", we, 0);
        step();
        if (tmo) begin
            for (int i = 0; i < TMO; i++) begin
                req  = (i == TMO - 1) ? nreq : 4'($urandom);
                fvld = 1'b0;
                @(negedge clk);
                chk("tmo_busy", busy, 1);
                chk("tmo_we", we, 0);
                chk("tmo_ack", ack, 0);
                step();
            end
        end else begin
            for (int f = 0; f < nfl; f++) begin
                gap = $urandom_range(0, gapmax);
                for (int j = 0; j < gap; j++) begin
                    fvld = 1'b0;
                    req  = 4'($urandom);
                    @(negedge clk);
                    chk("gap_busy", busy, 1);
                    chk("gap_we", we, 0);
                    step();
                end
                fvld = 1'b1;
                if (nfl == 1)            pkti = PKT_SGL;
                else if (f == 0)         pkti = PKT_HEAD;
                else if (f == nfl - 1)   pkti = PKT_TAIL;
                else                     pkti = ($urandom_range(0, 1) != 0) ? PKT_HEAD : PKT_BODY;
                req = (f == nfl - 1) ? nreq : 4'($urandom);
                @(negedge clk);
                chk("flit_we", we, 1);
                chk("flit_busy", busy, 1);
                chk("flit_ack", ack, 0);
                chk("flit_sel", sel, g);
                step();
                fvld = 1'b0;
            end
        end
        mptr = (g + 1) % 4;
        if (tmo) merr = 1'b1;
    endtask

    task automatic send(input logic [3:0] r, input int nfl, input int gapmax, input bit tmo);
        req = r;
        pkt(r, nfl, gapmax, tmo, 4'b0000);
        idle(1);
    endtask

    initial begin
        logic [3:0] r;
        rst  = 1'b0;
        req  = 4'b0000;
        fvld = 1'b0;
        pkti = PKT_BODY;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", we, 0);
        chk("rst_err", err, 0);
        step();
        rst = 1'b1;
        idle(2);

        // head/body/tail from input 2
        send(4'b0100, 3, 0, 1'b0);
        // ptr now 3: input 3 beats 0 and 1
        send(4'b1011, 2, 0, 1'b0);

        // all requesting, back-to-back two-flit packets
        req = 4'b1111;
        for (int k = 0; k < 5; k++)
            pkt(4'b1111, 2, 0, 1'b0, (k == 4) ? 4'b0000 : 4'b1111);
        idle(1);

        // single-flit packet
        send(4'b0001, 1, 0, 1'b0);

        // gaps of up to 3 idle cycles never trip the watchdog
        for (int k = 0; k < 4; k++)
            send(4'($urandom_range(1, 15)), 4, 3, 1'b0);
        @(negedge clk);
        chk("gap_err", err, 0);
        step();

        // watchdog release, then sticky err through normal packets
        send(4'b0010, 0, 0, 1'b1);
        send(4'b0111, 2, 1, 1'b0);
        send(4'b0001, 1, 0, 1'b0);

        // random traffic
        for (int k = 0; k < 20; k++) begin
            r = 4'($urandom_range(1, 15));
            send(r, $urandom_range(1, 4), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        // park ptr at 2, then reset mid-transfer
        send(4'b0010, 1, 0, 1'b0);
        req = 4'b0010;
        step();
        step();
        fvld = 1'b1;
        pkti = PKT_BODY;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_err", err, 0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        fvld = 1'b0;
        mptr = 0;
        merr = 1'b0;
        req  = 4'b1010;
        pkt(4'b1010, 2, 0, 1'b0, 4'b0000);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/osbm.md
Name: osbm

Overview:
- Output-side switch arbiter for one router output port. Sits directly downstream of the four input-side buffer managers.
- Collects one request bit from each input port and grants the port to one input with a single-cycle ack pulse. Drives the crossbar select.
- Holds the grant while flits stream through, and writes them to the output FIFO. Releases the port on a tail flit, or on a watchdog timeout.
- Fairness is round-robin across the four inputs.

Parameters:
TMO_W, 8, width of the watchdog counter
TMO, 255, number of consecutive idle cycles in XFER that forces release (1..2^TMO_W-1)

Ports:
clk    in   1  clock; all state updates on posedge
rst    in   1  asynchronous, active-low reset (asserted when 0)
req    in   4  bit i = input port i requests this output; held until acked
ack    out  4  one-hot grant pulse, exactly one cycle, registered
sel    out  2  crossbar select = index of the granted input
busy   out  1  output port owned (ACK or XFER state)
fvld   in   1  flit from the selected input is valid on the crossbar this cycle
pkti   in   2  type of that flit: 10 head, 00 body, 11 tail, 01 single
we     out  1  write enable to the output FIFO
err    out  1  sticky watchdog-release flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, cnt=0, ack=0000, sel=00, busy=0, we=0, err=0.
- States (2-bit encoding):
  - IDLE=00.
  - ACK=01.
  - XFER=10.
  - 11 is illegal and returns to IDLE with no outputs asserted.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, g = first set bit of req scanning ptr, ptr+1, ... mod 4.
  - Register sel<=g and go to ACK.
- ACK (exactly 1 cycle):
  - ack = one-hot(sel), busy=1, cnt<=0.
  - Go to XFER unconditionally.
- XFER:
  - busy=1, ack=0000, we = fvld (combinational, same cycle).
  - If fvld and pkti is 11 or 01: go to IDLE and set ptr<=sel+1 (mod 4). The tail flit itself is written (we=1 that cycle).
  - If fvld and any other type: stay, cnt<=0.
  - If !fvld: cnt<=cnt+1. When cnt==TMO-1 and !fvld: go to IDLE, ptr<=sel+1, err<=1.
- Latency:
  - req to ack is 1 cycle: ack is visible on the cycle after req is first seen in IDLE.
  - After release, the next grant evaluation happens in IDLE. There is therefore a 1-cycle bubble between back-to-back packets.
- req changes while in ACK or XFER are ignored. A requester dropping req before ack does not cancel the grant sequence.
- A head flit (10) seen in XFER is written as data. It does not restart arbitration.
- err stays set until reset. No other clear path exists.
- Reset asserted mid-XFER returns to IDLE immediately. we and ack drop asynchronously.
- ptr advances only on release, never on grant. A port that loses arbitration keeps its position.

Decomposition:
- Shared package router_pkg holds:
  - flit-type constants PKT_HEAD=2'b10, PKT_BODY=2'b00, PKT_TAIL=2'b11, PKT_SGL=2'b01;
  - N_PORT=4;
  - the osbm state enum.
- One sub-module: rr_pick, a combinational round-robin chooser (req[3:0], ptr[1:0] -> gnt_idx[1:0], any). Also reusable for the input-side arbitration.

Test Plan:
- Reset then req=0100 → ack=0100 for exactly one cycle, sel=10, busy=1; feed head, body, tail with fvld=1 → we=1 for 3 cycles; return to IDLE; ptr=11.
- req=1111 held, each packet 2 flits (head, tail) → grant order 0,1,2,3,0 with sel=00,01,10,11,00; one idle cycle between packets.
- Single-flit packet (pkti=01, fvld=1) on the first XFER cycle → release after 1 write; busy low on the next cycle.
- TMO=4, grant input 1, then fvld=0 → release after 4 idle cycles; err=1 and stays 1 through subsequent normal packets; ptr=10.
- fvld gaps of 3 cycles between flits with TMO=4 → no timeout; cnt resets on each flit; packet completes, err=0.
- Assert rst=0 mid-XFER → ack=0000, we=0, busy=0, sel=00 immediately; after deassertion req=0010 is granted first (ptr=0 scan).
